// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared states, opcode/funct/ALU constants and per-state control decode
package multicycle_pkg;

    localparam int OP_BITS   = 6;
    localparam int ALUC_BITS = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE,
        S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_EXEC_MEM, S_MEM_RD, S_MEM_WR, S_WB_MEM,
        S_EXEC_BR, S_TRAP
    } state_t;

    localparam logic [OP_BITS-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_BITS-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_BITS-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_BITS-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_BITS-1:0] OP_BEQ   = 6'b000100;

    localparam logic [OP_BITS-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_BITS-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_BITS-1:0] FN_AND = 6'b100100;
    localparam logic [OP_BITS-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_BITS-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUC_BITS-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUC_BITS-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUC_BITS-1:0] ALU_AND = 3'b000;
    localparam logic [ALUC_BITS-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUC_BITS-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic                 instr_ready;
        logic                 pc_src;
        logic                 reg_we;
        logic                 mem_we;
        logic                 reg_dst;
        logic                 alu_src;
        logic                 mem_to_reg;
        logic [ALUC_BITS-1:0] alu_control;
        logic                 busy;
        logic                 done;
        logic                 illegal;
    } ctrl_t;

    // ALU lines stay driven through write-back so the datapath result is stable when written
    function automatic ctrl_t ctrl_for(input state_t s, input logic [ALUC_BITS-1:0] aluc);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_FETCH:    c.instr_ready = 1'b1;
            S_EXEC_R:   c.alu_control = aluc;
            S_WB_R: begin
                c.alu_control = aluc;
                c.reg_dst     = 1'b1;
                c.reg_we      = 1'b1;
                c.done        = 1'b1;
            end
            S_EXEC_I, S_EXEC_MEM: begin
                c.alu_src     = 1'b1;
                c.alu_control = aluc;
            end
            S_WB_I: begin
                c.alu_src     = 1'b1;
                c.alu_control = aluc;
                c.reg_we      = 1'b1;
                c.done        = 1'b1;
            end
            S_MEM_WR: begin
                c.alu_src     = 1'b1;
                c.alu_control = aluc;
                c.mem_we      = 1'b1;
                c.done        = 1'b1;
            end
            S_MEM_RD: begin
                c.alu_src     = 1'b1;
                c.alu_control = aluc;
                c.mem_to_reg  = 1'b1;
            end
            S_WB_MEM: begin
                c.alu_src     = 1'b1;
                c.alu_control = aluc;
                c.mem_to_reg  = 1'b1;
                c.reg_we      = 1'b1;
                c.done        = 1'b1;
            end
            S_EXEC_BR: begin
                c.alu_control = aluc;
                c.pc_src      = 1'b1;
                c.done        = 1'b1;
            end
            S_TRAP:     c.illegal = 1'b1;
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - opcode/funct to ALU control, plus funct legality
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [OP_BITS-1:0]   op_i,
    input  logic [OP_BITS-1:0]   funct_i,
    output logic [ALUC_BITS-1:0] alu_control_o,
    output logic                 funct_legal_o
);

    logic [ALUC_BITS-1:0] r_aluc;

    always_comb begin
        r_aluc        = ALU_ADD;
        funct_legal_o = 1'b1;
        case (funct_i)
            FN_ADD:  r_aluc = ALU_ADD;
            FN_SUB:  r_aluc = ALU_SUB;
            FN_AND:  r_aluc = ALU_AND;
            FN_OR:   r_aluc = ALU_OR;
            FN_SLT:  r_aluc = ALU_SLT;
            default: funct_legal_o = 1'b0;
        endcase
    end

    assign alu_control_o = (op_i == OP_RTYPE) ? r_aluc :
                           (op_i == OP_BEQ)   ? ALU_SUB : ALU_ADD;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM; define MEM_WAIT_EN to add mem_ready wait states
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OP_W   = OP_BITS,
    parameter int ALUC_W = ALUC_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              zero,
`ifdef MEM_WAIT_EN
    input  logic              mem_ready,
`endif
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_src,
    output logic              reg_we,
    output logic              mem_we,
    output logic              reg_dst,
    output logic              alu_src,
    output logic              mem_to_reg,
    output logic [ALUC_W-1:0] alu_control,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    state_t               state_q, state_d;
    logic [OP_W-1:0]      op_q, op_d, funct_q, funct_d;
    ctrl_t                ctrl_q;
    logic [ALUC_BITS-1:0] aluc;
    logic                 funct_legal;
    logic                 mem_go;
    logic                 fire;
    logic                 unused_instr;

    assign unused_instr = ^instr[25:6];

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    alu_decoder u_alu_decoder (
        .op_i          (op_d),
        .funct_i       (funct_d),
        .alu_control_o (aluc),
        .funct_legal_o (funct_legal)
    );

    assign fire = (state_q == S_FETCH) && instr_valid;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: if (instr_valid) begin
                state_d = S_DECODE;
                op_d    = instr[31:26];
                funct_d = instr[5:0];
            end
            S_DECODE: begin
                case (op_q)
                    OP_RTYPE:     state_d = funct_legal ? S_EXEC_R : S_TRAP;
                    OP_LW, OP_SW: state_d = S_EXEC_MEM;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_EXEC_BR;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_EXEC_MEM: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_go) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_go) state_d = run ? S_FETCH : S_IDLE;
            S_WB_R, S_WB_I, S_WB_MEM, S_EXEC_BR:
                        state_d = run ? S_FETCH : S_IDLE;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Moore outputs are registered by decoding the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            funct_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            ctrl_q  <= ctrl_for(state_d, aluc);
        end
    end

    assign instr_ready = ctrl_q.instr_ready;
    assign ir_we       = fire;
    assign pc_we       = fire | (ctrl_q.pc_src & zero);
    assign pc_src      = ctrl_q.pc_src;
    assign reg_we      = ctrl_q.reg_we;
    assign mem_we      = ctrl_q.mem_we;
    assign reg_dst     = ctrl_q.reg_dst;
    assign alu_src     = ctrl_q.alu_src;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign alu_control = ctrl_q.alu_control;
    assign busy        = ctrl_q.busy;
    assign done        = ctrl_q.done & (mem_go | ~ctrl_q.mem_we);
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized bench for multicycle_ctrl against a latency-table model
module tb_multicycle_ctrl;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_FETCH = 1, M_BUSY = 2, M_TRAP = 3;
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_BAD = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        instr_ready, ir_we, pc_we, pc_src, reg_we, mem_we;
    logic        reg_dst, alu_src, mem_to_reg, busy, done, illegal;
    logic [2:0]  alu_control;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    int         m_mode = M_IDLE;
    int         m_k = 0;
    int         m_cls = C_BAD;
    logic [2:0] m_aluc = '0;

    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    wire [14:0] outvec = {instr_ready, ir_we, pc_we, pc_src, reg_we, mem_we, reg_dst,
                          alu_src, mem_to_reg, alu_control, busy, done, illegal};

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .zero        (zero),
`ifdef MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .reg_we      (reg_we),
        .mem_we      (mem_we),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .alu_control (alu_control),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    function automatic void classify(input logic [31:0] w, output int cls, output logic [2:0] ac);
        logic [5:0] op, fn;
        op  = w[31:26];
        fn  = w[5:0];
        cls = C_BAD;
        ac  = 3'b010;
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: begin cls = C_R; ac = 3'b010; end
                6'b100010: begin cls = C_R; ac = 3'b110; end
                6'b100100: begin cls = C_R; ac = 3'b000; end
                6'b100101: begin cls = C_R; ac = 3'b001; end
                6'b101010: begin cls = C_R; ac = 3'b111; end
                default:   cls = C_BAD;
            endcase
        end else if (op == 6'b100011) cls = C_LW;
        else if (op == 6'b101011) cls = C_SW;
        else if (op == 6'b001000) cls = C_I;
        else if (op == 6'b000100) begin cls = C_BR; ac = 3'b110; end
    endfunction

    function automatic int last_k(input int cls);
        if (cls == C_BR) return 3;
        if (cls == C_LW) return 5;
        return 4;
    endfunction

    function automatic logic mem_ok();
        return !WAIT_EN || mem_ready;
    endfunction

    // Expected outputs from instruction class and cycle count since the handshake (handshake = 1)
    function automatic logic [14:0] model_out();
        logic ir, irw, pcw, pcs, rw, mw, rd, as, m2r, b, d, il;
        logic [2:0] ac;
        {ir, irw, pcw, pcs, rw, mw, rd, as, m2r, b, d, il} = '0;
        ac = '0;
        if (rst) return '0;
        case (m_mode)
            M_FETCH: begin ir = 1; b = 1; irw = instr_valid; pcw = instr_valid; end
            M_TRAP:  begin b = 1; il = 1; end
            M_BUSY: begin
                b = 1;
                if (m_k >= 3 && m_cls != C_BAD) begin
                    ac = m_aluc;
                    as = (m_cls == C_I) || (m_cls == C_LW) || (m_cls == C_SW);
                end
                case (m_cls)
                    C_BR: if (m_k == 3) begin pcw = zero; pcs = 1; d = 1; end
                    C_R:  if (m_k == 4) begin rd = 1; rw = 1; d = 1; end
                    C_I:  if (m_k == 4) begin rw = 1; d = 1; end
                    C_SW: if (m_k == 4) begin mw = 1; d = mem_ok(); end
                    C_LW: begin
                        if (m_k == 4) m2r = 1;
                        if (m_k == 5) begin m2r = 1; rw = 1; d = 1; end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return {ir, irw, pcw, pcs, rw, mw, rd, as, m2r, ac, b, d, il};
    endfunction

    always @(posedge clk) begin
        int c;
        logic [2:0] a;
        if (rst) m_mode <= M_IDLE;
        else case (m_mode)
            M_IDLE:  if (run) m_mode <= M_FETCH;
            M_FETCH: if (instr_valid) begin
                classify(instr, c, a);
                m_cls  <= c;
                m_aluc <= a;
                m_k    <= 2;
                m_mode <= M_BUSY;
            end
            M_BUSY: begin
                if (m_cls == C_BAD) m_mode <= M_TRAP;
                else if (m_k == last_k(m_cls)) begin
                    if (m_cls != C_SW || mem_ok()) m_mode <= run ? M_FETCH : M_IDLE;
                end else if (!(m_k == 4 && m_cls == C_LW && !mem_ok())) m_k <= m_k + 1;
            end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        logic [14:0] exp_v;
        if (checking) begin
            exp_v = model_out();
            vectors++;
            if (outvec !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, outvec, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", int'(outvec), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] next_w, input logic z,
                         input bit keep, input int drop_at, input int low_until, input int bound,
                         output int lat, output logic [14:0] dv, output int mw_cnt);
        int guard;
        lat = -1; dv = '0; mw_cnt = 0; guard = 0;
        @(posedge clk); #1;
        instr = w; zero = z; instr_valid = 1'b1; mem_ready = (low_until < 1);
        @(negedge clk);
        while (!instr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) return;
        for (int c = 2; c <= bound; c++) begin
            @(posedge clk); #1;
            if (!keep) instr_valid = 1'b0;
            if (c == 2) instr = next_w;
            if (c == drop_at) run = 1'b0;
            mem_ready = (c > low_until);
            @(negedge clk);
            if (mem_we) mw_cnt++;
            if (done) begin
                lat = c;
                dv  = outvec;
                return;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1: begin w[31:26] = 6'b000000; w[5:0] = fn_tab[$urandom_range(0, 4)]; end
            2:    w[31:26] = 6'b000000;
            3, 4: w[31:26] = 6'b100011;
            5:    w[31:26] = 6'b101011;
            6:    w[31:26] = 6'b001000;
            7, 8: w[31:26] = 6'b000100;
            default: ;
        endcase
        return w;
    endfunction

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0008;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_BADO = 32'hFC00_0000;
    localparam logic [31:0] I_BADF = 32'h0022_1807;

    initial begin
        int lat, mw, cnt, c2;
        logic [14:0] dv;
        #1 rst = 1'b1;
        #1 checking = 1'b1;
        do_reset();

        run = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_ready && !ir_we && busy && !reg_we && !mem_we) cnt++;
        end
        check("fetch_hold_cycles", cnt, 10);

        issue(I_ADD, I_ADD, 1'b0, 1'b0, 0, 0, 40, lat, dv, mw);
        check("add_latency", lat, 4);
        check("add_wb_lines", int'({dv[10], dv[8], dv[5:3]}), 5'b11010);
        check("add_no_mem_we", mw, 0);

        issue(I_LW, I_SW, 1'b0, 1'b1, 0, 0, 40, lat, dv, mw);
        check("lw_latency", lat, 5);
        check("lw_wb_lines", int'({dv[10], dv[6]}), 2'b11);
        c2 = lat;
        while (!(c2 > lat && done) && c2 < 30) begin
            @(posedge clk); #1;
            @(negedge clk);
            c2++;
        end
        check("lw_sw_retire_cycles", c2, 9);
        check("sw_mem_we_at_done", int'(mem_we), 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;

        issue(I_BEQ, I_BEQ, 1'b1, 1'b0, 0, 0, 40, lat, dv, mw);
        check("beq_taken_latency", lat, 3);
        check("beq_taken_pc", int'({dv[12], dv[11]}), 2'b11);
        issue(I_BEQ, I_BEQ, 1'b0, 1'b0, 0, 0, 40, lat, dv, mw);
        check("beq_not_taken_latency", lat, 3);
        check("beq_not_taken_pcwe_done", int'({dv[12], dv[1]}), 2'b01);

        issue(I_BADO, I_BADO, 1'b0, 1'b0, 0, 0, 12, lat, dv, mw);
        check("trap_op_no_done", lat, -1);
        check("trap_op_flags", int'({illegal, instr_ready, busy}), 3'b101);
        do_reset();
        @(negedge clk);
        check("after_reset_flags", int'({illegal, busy, instr_ready}), 3'b000);

        issue(I_BADF, I_BADF, 1'b0, 1'b0, 0, 0, 12, lat, dv, mw);
        check("trap_funct_no_done", lat, -1);
        check("trap_funct_flags", int'({illegal, instr_ready, busy}), 3'b101);
        do_reset();

        issue(I_LW, I_LW, 1'b0, 1'b0, 3, 0, 40, lat, dv, mw);
        check("lw_run_drop_latency", lat, 5);
        @(negedge clk);
        check("lw_run_drop_idle_busy", int'(busy), 0);
        @(posedge clk); #1;
        run = 1'b1;

        if (WAIT_EN) begin
            issue(I_SW, I_SW, 1'b0, 1'b0, 0, 6, 40, lat, dv, mw);
            check("sw_wait_latency", lat, 7);
            check("sw_wait_mem_we_cycles", mw, 4);
        end

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 99) == 0 || (m_mode == M_TRAP && $urandom_range(0, 3) == 0))
                rst = 1'b1;
            run         = ($urandom_range(0, 99) < 85);
            instr_valid = ($urandom_range(0, 99) < 70);
            instr       = rand_instr();
            zero        = 1'($urandom_range(0, 1));
            mem_ready   = ($urandom_range(0, 99) < 60);
        end

        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
